pwm_bank: RTL and testbench
===========================

# pwm_bank

Multi-channel PWM generator with a shared free-running counter, per-channel double-buffered duty registers, and an optional per-channel "breathe" mode that ramps duty up and down automatically. It is the parametrised successor to the fixed-compare per-LED PWM instances: the top level drives the onboard LEDs from `pwm[]` and programs duties through a simple write port, such as from the AVR SPI/serial command path.

## Interface
- `CHANNELS`, default 8: number of PWM outputs, ≥1.
- `CTR_LEN`, default 8: counter/duty width; period = 2^CTR_LEN cycles.
- `FADE_DIV`, default 16: PWM periods per breathe step, ≥1.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write strobe, one cycle per write.
- `wr_addr`  in  $clog2(CHANNELS) (min 1)  target channel.
- `wr_mode`  in  1  0 = static, 1 = breathe.
- `wr_duty`  in  CTR_LEN  static duty, or breathe ceiling.
- `pwm`  out  CHANNELS  registered PWM outputs.
- `period_start`  out  1  registered one-cycle pulse marking the first cycle of each output period.

## Operation
- Reset values:
  - ctr = 0, fade_ctr = 0.
  - All shadow/active duty = 0, all modes static, breathe level = 0, direction = up.
  - `pwm` = 0, `period_start` = 0.
- Counter: `ctr` increments every cycle and wraps 2^CTR_LEN−1 → 0. A boundary is the cycle where ctr = max.
- Output: `pwm[i]` is registered as (active_duty[i] > ctr).
  - Duty 0 → never high.
  - Duty max → high 2^CTR_LEN−1 of 2^CTR_LEN cycles.
- Write:
  - On `wr_en` with `wr_addr` < CHANNELS, shadow_duty/shadow_mode[wr_addr] are updated at the next edge.
  - Writes with `wr_addr` ≥ CHANNELS are ignored.
  - Writes never affect the period in progress.
- Boundary transfer: at each boundary, every channel loads its active state from the shadow values held before that edge. A write in the boundary cycle lands in the shadow and applies one period later.
  - Static mode: active_duty = shadow_duty.
  - Static → breathe: level = 0, direction = up, active_duty = 0.
  - Breathe → breathe: level is clamped to the ceiling if the ceiling dropped below it.
- Breathe stepping:
  - `fade_ctr` counts boundaries 0..FADE_DIV−1 and wraps.
  - At a boundary where fade_ctr = FADE_DIV−1, each breathe channel steps level ±1.
  - Direction reverses on reaching the ceiling (goes down) or 0 (goes up). The step that reaches the endpoint sets the new direction.
  - Ceiling 0 → level holds at 0.
  - active_duty = level.
- Simultaneous events: clamp, then step, within the same boundary edge. Stepping never exceeds the ceiling.

## Timing
- `pwm` and `period_start` lag the counter by one cycle. `period_start` is high in the cycle `pwm` reflects ctr = 0.
- A write is visible at `pwm` from the first `period_start` after the next boundary. Worst case is 2^CTR_LEN + 1 cycles, or one period more if written in the boundary cycle.
- Async `rst` clears all outputs immediately, mid-period included. After release, the first `period_start` occurs 1 cycle later (ctr = 0 registered).
- No combinational path from inputs to outputs.

## Structure
- Package `pwm_bank_pkg`: mode enum (`PWM_STATIC`, `PWM_BREATHE`) and the channel state record (shadow duty, mode, level, dir).
- Sub-module `pwm_channel`: holds one channel's shadow, active, and breathe state. It takes the shared `ctr`, `boundary` and `fade_step` strobes plus a decoded write enable, and is instantiated in a generate loop.
- The top holds `ctr`, `fade_ctr`, address decode and `period_start`.

## Test plan
- **Reset (CTR_LEN=8):** release `rst` → all `pwm` 0; `period_start` pulses every 256 cycles, the first 1 cycle after release.
- **Static duty:** write ch3 duty 64 static → from the following period, `pwm[3]` is high 64 cycles, low 192; other channels stay 0.
- **Extremes and address range:** duty 255 → high 255 of 256 cycles; duty 0 → never high; write to `wr_addr` ≥ CHANNELS → no channel changes.
- **Mid-period write:** ch0 at duty 200, write duty 10 when ctr = 100 → the current period completes with a 200-cycle high; the next period is high 10 cycles; no runt pulse.
- **Breathe (CTR_LEN=4, FADE_DIV=2):** ch1 breathe, ceiling 4 → per-period duty 0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1,0,0,1,…
  - Lowering the ceiling to 2 while level = 4 → level clamps to 2 at the next boundary, then ramps down.
- **Reset mid-ramp:** assert `rst` mid-period during breathe → `pwm` drops to 0 asynchronously; after release, all channels are static duty 0.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared types for the PWM bank: channel mode and direction encodings plus the
// per-channel state record. Duty/level fields are sized for the widest supported counter.
package pwm_bank_pkg;

  // Widest CTR_LEN the bank supports; narrower counters are zero-extended into these fields.
  localparam int DUTY_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    PWM_STATIC  = 1'b0,
    PWM_BREATHE = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  typedef struct packed {
    duty_t     duty;   // shadow duty (static) or ceiling (breathe)
    pwm_mode_e mode;   // shadow mode
    duty_t     level;  // breathe level currently applied
    pwm_dir_e  dir;    // breathe direction
  } chan_state_t;

  function automatic duty_t clamp_level(input duty_t level, input duty_t ceil);
    return (level > ceil) ? ceil : level;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow registers written at any time, active duty reloaded at the
// period boundary, and an optional triangle "breathe" ramp stepped by fade_step.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int CTR_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CTR_LEN-1:0] ctr,
  input  logic               boundary,
  input  logic               fade_step,
  input  logic               wr,
  input  pwm_mode_e          wr_mode,
  input  logic [CTR_LEN-1:0] wr_duty,
  output logic               pwm
);

  chan_state_t st, st_n;
  pwm_mode_e   act_mode, act_mode_n;
  duty_t       active, active_n;
  duty_t       lvl;
  pwm_dir_e    dir;

  always_comb begin
    st_n       = st;
    act_mode_n = act_mode;
    active_n   = active;
    lvl        = st.level;
    dir        = st.dir;

    if (wr) begin
      st_n.duty = DUTY_W'(wr_duty);
      st_n.mode = wr_mode;
    end

    // Transfer reads st (pre-edge shadow), so a write in the boundary cycle waits a period.
    if (boundary) begin
      act_mode_n = st.mode;
      if (st.mode == PWM_STATIC) begin
        active_n = st.duty;
      end else if (act_mode == PWM_STATIC) begin
        st_n.level = '0;
        st_n.dir   = DIR_UP;
        active_n   = '0;
      end else begin
        lvl = clamp_level(st.level, st.duty);
        if (fade_step) begin
          if (st.duty == '0) begin
            lvl = '0;
            dir = DIR_UP;
          end else if ((dir == DIR_UP && lvl < st.duty) || lvl == '0) begin
            lvl = lvl + DUTY_W'(1);
            dir = (lvl >= st.duty) ? DIR_DOWN : DIR_UP;
          end else begin
            lvl = lvl - DUTY_W'(1);
            dir = (lvl == '0) ? DIR_UP : DIR_DOWN;
          end
        end
        st_n.level = lvl;
        st_n.dir   = dir;
        active_n   = lvl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= '{duty: '0, mode: PWM_STATIC, level: '0, dir: DIR_UP};
      act_mode <= PWM_STATIC;
      active   <= '0;
      pwm      <= 1'b0;
    end else begin
      st       <= st_n;
      act_mode <= act_mode_n;
      active   <= active_n;
      pwm      <= (active > DUTY_W'(ctr));
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared free-running counter, breathe step prescaler,
// write-address decode and the period_start marker; per-channel logic lives in pwm_channel.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter  int CHANNELS = 8,
  parameter  int CTR_LEN  = 8,
  parameter  int FADE_DIV = 16,
  localparam int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                wr_mode,
  input  logic [CTR_LEN-1:0]  wr_duty,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);

  logic [CTR_LEN-1:0] ctr;
  logic [FW-1:0]      fade_ctr;
  logic               boundary;
  logic               fade_step;

  assign boundary  = (ctr == '1);
  assign fade_step = boundary && (fade_ctr == FW'(FADE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr          <= '0;
      fade_ctr     <= '0;
      period_start <= 1'b0;
    end else begin
      ctr          <= ctr + CTR_LEN'(1);
      // Registered like pwm, so it marks the cycle in which pwm reflects ctr = 0.
      period_start <= (ctr == '0);
      if (boundary)
        fade_ctr <= (fade_ctr == FW'(FADE_DIV - 1)) ? '0 : fade_ctr + FW'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic wr_sel;
    // Out-of-range addresses match no channel and are dropped.
    assign wr_sel = wr_en && (wr_addr == AW'(g));

    pwm_channel #(.CTR_LEN(CTR_LEN)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ctr       (ctr),
      .boundary  (boundary),
      .fade_step (fade_step),
      .wr        (wr_sel),
      .wr_mode   (pwm_mode_e'(wr_mode)),
      .wr_duty   (wr_duty),
      .pwm       (pwm[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: a 6-channel 8-bit instance for static duty, addressing
// and write timing, and a 2-channel 4-bit FADE_DIV=2 instance for breathe behaviour.
module tb_pwm_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, a_wr_en, a_wr_mode, a_ps;
  logic [2:0] a_wr_addr;
  logic [7:0] a_wr_duty;
  logic [5:0] a_pwm;

  logic       rst_b, b_wr_en, b_wr_mode, b_ps;
  logic [0:0] b_wr_addr;
  logic [3:0] b_wr_duty;
  logic [1:0] b_pwm;

  pwm_bank #(.CHANNELS(6), .CTR_LEN(8), .FADE_DIV(16)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_mode(a_wr_mode),
    .wr_duty(a_wr_duty), .pwm(a_pwm), .period_start(a_ps)
  );

  pwm_bank #(.CHANNELS(2), .CTR_LEN(4), .FADE_DIV(2)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_mode(b_wr_mode),
    .wr_duty(b_wr_duty), .pwm(b_pwm), .period_start(b_ps)
  );

  typedef int cnt_t [6];
  typedef struct {
    int   addr;
    int   duty;
    cnt_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_wr(input int dut, input bit en, input int addr, input int duty, input bit mode);
    if (dut == 0) begin
      a_wr_en = en; a_wr_addr = 3'(addr); a_wr_duty = 8'(duty); a_wr_mode = mode;
    end else begin
      b_wr_en = en; b_wr_addr = 1'(addr); b_wr_duty = 4'(duty); b_wr_mode = mode;
    end
  endtask

  task automatic wait_ps(input int dut);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ((dut == 0) ? a_ps : b_ps) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start dut%0d: got no pulse, expected one within 600 cycles", dut);
    end
  endtask

  // Counts high cycles per channel over one full period, optionally pulsing a write at sample wr_at.
  task automatic measure(input int dut, input int wr_at, input int addr, input int duty,
                         input bit mode, output cnt_t cnt);
    int len = (dut == 0) ? 256 : 16;
    foreach (cnt[c]) cnt[c] = 0;
    wait_ps(dut);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      drive_wr(dut, (i == wr_at), addr, duty, mode);
      for (int c = 0; c < 6; c++) begin
        if (dut == 0) cnt[c] += int'(a_pwm[c]);
        else if (c < 2) cnt[c] += int'(b_pwm[c]);
      end
    end
    drive_wr(dut, 1'b0, 0, 0, 1'b0);
  endtask

  vec_t vecs[7];
  int   seq_ramp[19]  = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0, 1};
  int   seq_clamp[8]  = '{4, 2, 1, 1, 0, 0, 1, 1};

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cnt_t cnt, junk;
    int   n;

    vecs[0] = '{addr: 3, duty: 64,  exp: '{0, 0, 0,   64, 0, 0}};
    vecs[1] = '{addr: 2, duty: 255, exp: '{0, 0, 255, 64, 0, 0}};
    vecs[2] = '{addr: 5, duty: 1,   exp: '{0, 0, 255, 64, 0, 1}};
    vecs[3] = '{addr: 2, duty: 0,   exp: '{0, 0, 0,   64, 0, 1}};
    vecs[4] = '{addr: 6, duty: 200, exp: '{0, 0, 0,   64, 0, 1}};
    vecs[5] = '{addr: 7, duty: 128, exp: '{0, 0, 0,   64, 0, 1}};
    vecs[6] = '{addr: 0, duty: 200, exp: '{200, 0, 0, 64, 0, 1}};

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_wr(0, 1'b0, 0, 0, 1'b0);
    drive_wr(1, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_pwm_a", int'(a_pwm), 0);
    check("reset_ps_a", int'(a_ps), 0);

    // First period_start one cycle after release, then every 256 cycles.
    rst_a = 1'b0;
    @(negedge clk);
    check("first_ps", int'(a_ps), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ps && n < 600);
    check("ps_spacing", n, 256);

    measure(0, -1, 0, 0, 1'b0, cnt);
    foreach (cnt[c]) check($sformatf("idle_ch%0d", c), cnt[c], 0);

    for (int v = 0; v < 7; v++) begin
      measure(0, 0, vecs[v].addr, vecs[v].duty, 1'b0, junk);
      measure(0, -1, 0, 0, 1'b0, cnt);
      for (int c = 0; c < 6; c++)
        check($sformatf("vec%0d_ch%0d", v, c), cnt[c], vecs[v].exp[c]);
    end

    // Mid-period write: current period keeps 200, next period gets 10.
    measure(0, 100, 0, 10, 1'b0, cnt);
    check("midwrite_cur", cnt[0], 200);
    measure(0, -1, 0, 0, 1'b0, cnt);
    check("midwrite_next", cnt[0], 10);

    // Write in the boundary cycle (ctr = 255) applies one period later.
    measure(0, 254, 5, 20, 1'b0, cnt);
    check("bndwrite_cur", cnt[5], 1);
    measure(0, -1, 0, 0, 1'b0, cnt);
    check("bndwrite_next", cnt[5], 1);
    measure(0, -1, 0, 0, 1'b0, cnt);
    check("bndwrite_late", cnt[5], 20);

    // Breathe ramp, entry written in period 1 so the entry boundary coincides with a fade step.
    @(negedge clk);
    rst_b = 1'b0;
    measure(1, -1, 0, 0, 1'b0, junk);
    measure(1, 0, 1, 4, 1'b1, junk);
    for (int j = 0; j < 19; j++) begin
      measure(1, -1, 0, 0, 1'b0, cnt);
      check($sformatf("ramp_p%0d", j + 2), cnt[1], seq_ramp[j]);
      if (j == 0) check("ramp_ch0", cnt[0], 0);
    end

    // Ceiling lowered to 2 while level = 4.
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    measure(1, -1, 0, 0, 1'b0, junk);
    measure(1, 0, 1, 4, 1'b1, junk);
    for (int j = 2; j < 10; j++) measure(1, -1, 0, 0, 1'b0, junk);
    for (int j = 0; j < 8; j++) begin
      measure(1, (j == 0) ? 3 : -1, 1, 2, 1'b1, cnt);
      check($sformatf("clamp_p%0d", j + 10), cnt[1], seq_clamp[j]);
    end

    // Period 18 runs at level 2: reset while pwm[1] is high.
    wait_ps(1);
    @(negedge clk);
    check("ramp_high_before_rst", int'(b_pwm[1]), 1);
    #2 rst_b = 1'b1;
    #1;
    check("async_rst_pwm", int'(b_pwm), 0);
    check("async_rst_ps", int'(b_ps), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("rst_b_first_ps", int'(b_ps), 1);
    for (int j = 0; j < 4; j++) begin
      measure(1, -1, 0, 0, 1'b0, cnt);
      check($sformatf("post_rst_p%0d_ch0", j + 1), cnt[0], 0);
      check($sformatf("post_rst_p%0d_ch1", j + 1), cnt[1], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
